// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer. in_ready depends only on local state, so no combinational path
// crosses the stage in either direction. A flush empties both entries, and
// two saturating counters record stall and flush activity.
module pipe_stage_skid #(
   parameter int                 WIDTH  = 48,
   parameter logic [WIDTH-1:0]   BUBBLE = {WIDTH{1'b0}},
   parameter int                 CNTW   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNTW-1:0]  stall_cnt,
   output logic [CNTW-1:0]  flush_cnt
);

   // State encoding is {main_v, skid_v}; 2'b01 is unreachable.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_d, main_d_next;
   logic [WIDTH-1:0] skid_d, skid_d_next;
   logic             main_v, skid_v;
   logic             in_fire, out_fire;
   logic             stall_inc, flush_inc;

   assign main_v    = state_q[1];
   assign skid_v    = state_q[0];

   assign in_ready  = !skid_v;
   assign out_valid = main_v;
   assign out_data  = main_v ? main_d : BUBBLE;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   assign stall_inc = main_v & !out_ready;
   assign flush_inc = flush & (main_v | skid_v);

   // Next-state and next-data selection; flush overrides the handshake.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d     = state_q;
      main_d_next = main_d;
      skid_d_next = skid_d;
      if (flush) begin
         // A beat taken upstream this cycle is dropped; a downstream
         // transfer this cycle has already been sampled by the consumer.
         state_d     = EMPTY;
         main_d_next = BUBBLE;
         skid_d_next = BUBBLE;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d     = ONE;
                  main_d_next = in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d_next = in_data;
               end else if (in_fire) begin
                  state_d     = FULL;
                  skid_d_next = in_data;
               end else if (out_fire) begin
                  state_d     = EMPTY;
                  main_d_next = BUBBLE;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d     = ONE;
                  main_d_next = skid_d;
                  skid_d_next = BUBBLE;
               end
            end
            default: begin
               state_d     = EMPTY;
               main_d_next = BUBBLE;
               skid_d_next = BUBBLE;
            end
         endcase
      end
   end

   // State and payload registers; the payload registers are reset to BUBBLE
   // so that a stale beat can never reach out_data.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (rst) begin
         state_q <= EMPTY;
         main_d  <= BUBBLE;
         skid_d  <= BUBBLE;
      end else begin
         state_q <= state_d;
         main_d  <= main_d_next;
         skid_d  <= skid_d_next;
      end
   end

   // Saturating stall counter: cycles where the consumer holds off a beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_inc && (stall_cnt != {CNTW{1'b1}})) begin
         stall_cnt <= stall_cnt + CNTW'(1);
      end
   end

   // Saturating flush counter: flushes that actually kill a held beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt <= '0;
      end else if (flush_inc && (flush_cnt != {CNTW{1'b1}})) begin
         flush_cnt <= flush_cnt + CNTW'(1);
      end
   end

endmodule
